// File: rtl/adder_bist_pkg.sv
// Shared types for the adder BIST: FSM state encoding and default operand width.
// Imported by the sequencer and the golden adder.
package adder_bist_pkg;

    localparam int N_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/adder_bist_ref.sv
// Golden N-bit adder producing an N+1-bit sum; purely combinational, zero latency.
module adder_ref
    import adder_bist_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_bist.sv
// Exhaustive BIST sweep of an external N-bit adder: two cycles per vector (drive, sample),
// logging mismatch count and first failing operands; start is ignored mid-sweep.
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    output logic [N-1:0]   A,
    output logic [N-1:0]   B,
    input  logic [N-1:0]   S,
    input  logic           Cout,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*N:0]   err_count,
    output logic           fail_valid,
    output logic [N-1:0]   fail_A,
    output logic [N-1:0]   fail_B
);

    localparam logic [2*N-1:0] IDX_ONE = (2*N)'(1);
    localparam logic [2*N:0]   ERR_ONE = (2*N+1)'(1);

    state_t          state_q, state_d;
    logic [2*N-1:0]  idx_q, idx_d;
    logic [2*N:0]    err_q, err_d;
    logic            fail_vld_q, fail_vld_d;
    logic [N-1:0]    fail_a_q, fail_a_d;
    logic [N-1:0]    fail_b_q, fail_b_d;

    logic [N:0]      golden_sum;
    logic            mismatch;

    adder_ref #(.N(N)) u_adder_ref (
        .a   (A),
        .b   (B),
        .sum (golden_sum)
    );

    // Operands come straight from the index flops, so they cannot move between DRIVE and SAMPLE.
    assign A        = idx_q[2*N-1:N];
    assign B        = idx_q[N-1:0];
    assign mismatch = ({Cout, S} != golden_sum);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        err_d      = err_q;
        fail_vld_d = fail_vld_q;
        fail_a_d   = fail_a_q;
        fail_b_d   = fail_b_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = DRIVE;
                    idx_d      = '0;
                    err_d      = '0;
                    fail_vld_d = 1'b0;
                    fail_a_d   = '0;
                    fail_b_d   = '0;
                end
            end
            DRIVE: begin
                state_d = SAMPLE;
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + ERR_ONE;
                    if (!fail_vld_q) begin
                        fail_vld_d = 1'b1;
                        fail_a_d   = A;
                        fail_b_d   = B;
                    end
                end
                // Last vector leaves idx at all-ones so A/B hold max+max while DONE.
                if (&idx_q) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = DRIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            err_q      <= '0;
            fail_vld_q <= 1'b0;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            fail_vld_q <= fail_vld_d;
            fail_a_q   <= fail_a_d;
            fail_b_q   <= fail_b_d;
        end
    end

    assign busy       = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done       = (state_q == DONE);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign fail_valid = fail_vld_q;
    assign fail_A     = fail_a_q;
    assign fail_B     = fail_b_q;

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: a faulty-adder stand-in answers the BIST, and a per-vector table
// built from plain arithmetic predicts counts, first failure and the sweep timeline.
module tb_adder_bist;

    localparam int N  = 2;
    localparam int NV = 1 << (2 * N);
    localparam int NM = 1 << N;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic [N-1:0]   A, B, S;
    logic           Cout;
    logic           busy, done, pass;
    logic [2*N:0]   err_count;
    logic           fail_valid;
    logic [N-1:0]   fail_A, fail_B;

    int             total = 0;
    int             bad   = 0;
    int             mode  = 0;
    logic [NV-1:0]  mask  = '0;

    adder_bist #(.N(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .A          (A),
        .B          (B),
        .S          (S),
        .Cout       (Cout),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .fail_A     (fail_A),
        .fail_B     (fail_B)
    );

    always #5 clock = ~clock;

    // Adder under test: 0 correct, 1 Cout stuck at 0, 2 S[0] inverted, 3 S[0] inverted where mask bit set.
    function automatic logic [N:0] dut_model(input int md, input logic [NV-1:0] mk,
                                             input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] r;
        r = {1'b0, a} + {1'b0, b};
        case (md)
            1: r[N] = 1'b0;
            2: r[0] = ~r[0];
            3: if (mk[{a, b}]) r[0] = ~r[0];
            default: ;
        endcase
        return r;
    endfunction

    assign {Cout, S} = dut_model(mode, mask, A, B);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic run_sweep(input int md, input logic [NV-1:0] mk, input bit repulse);
        bit   exp_bad [NV];
        int   n_bad;
        int   first;
        int   running;
        int   v;
        logic [2*N-1:0] prev_ab;
        mode  = md;
        mask  = mk;
        n_bad = 0;
        first = -1;
        for (int i = 0; i < NV; i++) begin
            int a, b;
            a = i / NM;
            b = i % NM;
            exp_bad[i] = (dut_model(md, mk, N'(a), N'(b)) != (N+1)'(a + b));
            if (exp_bad[i]) begin
                n_bad++;
                if (first < 0) first = i;
            end
        end

        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;       // edge 0: start sampled
        start = 1'b0;
        check_eq("start_busy", busy, 1);
        check_eq("start_done", done, 0);
        check_eq("start_err_clr", err_count, 0);
        check_eq("start_fv_clr", fail_valid, 0);
        check_eq("start_ab", {A, B}, 0);
        prev_ab = {A, B};
        running = 0;

        for (int e = 1; e <= 2 * NV; e++) begin
            start = (repulse && (e == 9 || e == 10)) ? 1'b1 : 1'b0;
            @(posedge clock); #1;
            if (e % 2 == 1) begin
                v = (e - 1) / 2;
                check_eq("sample_ab_stable", {A, B}, prev_ab);
                check_eq("sample_a", A, v / NM);
                check_eq("sample_b", B, v % NM);
                check_eq("sample_busy", busy, 1);
            end else begin
                v = e / 2 - 1;
                running += exp_bad[v] ? 1 : 0;
                check_eq("running_err", err_count, running);
                if (e < 2 * NV) begin
                    check_eq("drive_ab", {A, B}, v + 1);
                    check_eq("drive_busy", busy, 1);
                end
                prev_ab = {A, B};
            end
            if (e < 2 * NV) check_eq("early_done", done, 0);
        end
        start = 1'b0;

        check_eq("end_done", done, 1);
        check_eq("end_busy", busy, 0);
        check_eq("end_pass", pass, (n_bad == 0) ? 1 : 0);
        check_eq("end_err", err_count, n_bad);
        check_eq("end_fv", fail_valid, (first >= 0) ? 1 : 0);
        check_eq("end_fail_a", fail_A, (first >= 0) ? first / NM : 0);
        check_eq("end_fail_b", fail_B, (first >= 0) ? first % NM : 0);
        check_eq("end_ab_hold", {A, B}, NV - 1);
        @(posedge clock); #1;
        check_eq("done_sticky", done, 1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass, 0);
        check_eq("rst_err", err_count, 0);
        check_eq("rst_fv", fail_valid, 0);
        check_eq("rst_ab", {A, B}, 0);
        reset = 1'b0;

        run_sweep(0, '0, 1'b0);     // healthy adder
        run_sweep(1, '0, 1'b1);     // Cout stuck 0, start re-pulsed while busy
        run_sweep(2, '0, 1'b0);     // S[0] inverted, restarted from DONE

        // Reset mid-sweep, with start held to confirm reset wins.
        mode = 2;
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check_eq("pre_rst_busy", busy, 1);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        start = 1'b0;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_ab", {A, B}, 0);
        check_eq("mid_rst_err", err_count, 0);
        check_eq("mid_rst_fv", fail_valid, 0);
        @(posedge clock); #1;
        check_eq("idle_hold", busy, 0);

        for (int t = 0; t < 6; t++) begin
            run_sweep(3, NV'($urandom), bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_bist.md
ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 SHALL have parameter N, default 2, meaning operand width in bits of the adder under test.
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-005 SHALL have port A  output  N  operand A driven to the adder under test.
REQ-006 SHALL have port B  output  N  operand B driven to the adder under test.
REQ-007 SHALL have port S  input  N  sum returned by the adder under test.
REQ-008 SHALL have port Cout  input  1  carry returned by the adder under test.
REQ-009 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have port done  output  1  high once a sweep has completed, until the next start or reset.
REQ-011 SHALL have port pass  output  1  high with done when no mismatch occurred.
REQ-012 SHALL have port err_count  output  2N+1  number of mismatching vectors in the current or last sweep.
REQ-013 SHALL have port fail_valid  output  1  high once a first mismatch has been recorded.
REQ-014 SHALL have port fail_A  output  N  A operand of the first mismatch.
REQ-015 SHALL have port fail_B  output  N  B operand of the first mismatch.

Function
REQ-016 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-017 SHALL hold a 2N-bit vector index idx; A = idx[2N-1:N], B = idx[N-1:0], so vectors run A-major, B-minor, from 0+0 to max+max.
REQ-018 IDLE or DONE with start=1 SHALL go to DRIVE, setting idx=0, err_count=0, fail_valid=0, fail_A=0, fail_B=0, done=0, pass=0.
REQ-019 DRIVE SHALL go unconditionally to SAMPLE, giving the adder one full cycle to settle.
REQ-020 SAMPLE SHALL compare {Cout,S} against A+B computed at N+1 bits; on mismatch it SHALL increment err_count and, if fail_valid=0, capture fail_A=A, fail_B=B and set fail_valid=1.
REQ-021 SAMPLE SHALL go to DONE if idx is all ones; otherwise it SHALL increment idx and go to DRIVE.
REQ-022 Timing: if start is sampled at edge 0, vector v SHALL be compared at edge 2v+2, and done SHALL rise at edge 2*2^(2N) (edge 32 for N=2).
REQ-023 busy SHALL equal 1 exactly in DRIVE and SAMPLE; done SHALL equal 1 exactly in DONE; pass SHALL equal done AND (err_count==0).
REQ-024 start SHALL be ignored while busy=1.
REQ-025 err_count SHALL not wrap: width 2N+1 holds the maximum 2^(2N).
REQ-026 A and B SHALL remain stable throughout each DRIVE/SAMPLE pair and SHALL hold the last vector in DONE.

Reset
REQ-027 reset=1 at a rising edge SHALL force IDLE, idx=0 (A=B=0), busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_A=0, fail_B=0, including mid-sweep.
REQ-028 reset SHALL take priority over start in the same cycle.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding and the default width N=2.
REQ-030 The golden sum SHALL be one combinational sub-module, adder_ref (N-bit inputs, N+1-bit sum), instantiated once.

Verification
REQ-031 Correct adder model, N=2, start pulse -> done and pass at 32 cycles, err_count=0, fail_valid=0.
REQ-032 Cout stuck at 0 -> err_count=6, fail_A=1, fail_B=3, pass=0.
REQ-033 S[0] inverted -> err_count=16, fail_A=0, fail_B=0, pass=0.
REQ-034 reset asserted 10 cycles after start -> next cycle IDLE, busy=0, done=0, A=B=0, err_count=0.
REQ-035 start re-pulsed while busy -> ignored, done still at cycle 32; start in DONE -> counters cleared, new 32-cycle sweep.
REQ-036 Every compare -> A, B unchanged since the preceding DRIVE cycle; vectors sequence 0+0, 0+1, ..., 3+3.
